page_leaf_arbiter: RTL and testbench
====================================

PAGE_LEAF_ARBITER -- requirements
Module: page_leaf_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6, number of requesters sharing one BFT leaf output.
REQ-002 Parameter PKT_W, default 49, leaf packet width; bit PKT_W-1 is the packet-valid bit.
REQ-003 Parameter MAX_RETRY, default 15, maximum consecutive resend cycles before a packet is dropped.
REQ-004 Parameter BURST_LEN, default 4, maximum consecutive packets per grant when the burst feature is compiled in.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ap_start  input  1  enables arbitration while high.
REQ-008 resend  input  1  BFT retransmit request for the packet currently on dout.
REQ-009 req_din_i  input  NUM_REQ*PKT_W  flattened requester packets; requester i occupies bits [i*PKT_W +: PKT_W].
REQ-010 req_valid_i  input  NUM_REQ  requester i has a packet.
REQ-011 req_ready_o  output  NUM_REQ  one-hot, combinational; packet i accepted this cycle.
REQ-012 dout_leaf_interface2bft  output  PKT_W  registered leaf packet to the BFT.
REQ-013 grant_id_o  output  3  registered index of the requester whose packet is on dout.
REQ-014 drop_o  output  1  registered one-cycle pulse when a packet is abandoned after MAX_RETRY.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and RETRY.
REQ-016 IDLE: dout, grant_id_o and drop_o SHALL be 0 and req_ready_o SHALL be 0; IDLE->RUN when ap_start=1.
REQ-017 RUN: the round-robin winner SHALL be the first valid requester searching upward from last_grant+1 modulo NUM_REQ.
REQ-018 RUN with a winner: req_ready_o[winner]=1 in that cycle; dout <= that packet with bit PKT_W-1 forced to 1; grant_id_o <= winner; last_grant <= winner.
REQ-019 RUN with no valid requester: dout SHALL be loaded with 0 (bubble) next cycle.
REQ-020 Resend is evaluated in any cycle where dout bit PKT_W-1 = 1; if resend=1, no request is accepted, dout and grant_id_o hold, and the state becomes (or stays) RETRY.
REQ-021 RETRY with resend=0: acts as RUN in the same cycle (accepts a new winner) and returns to RUN; retry count clears.
REQ-022 Retry count SHALL increment per held cycle; on the cycle resend=1 with count = MAX_RETRY, dout <= 0, drop_o pulses next cycle, count clears, state -> RUN.
REQ-023 ap_start=0 in RUN SHALL move to IDLE next cycle with no accept that cycle; in RETRY the held packet completes (resend=0 or drop) before IDLE.
REQ-024 last_grant SHALL update only on accept; bubbles, holds and drops leave it unchanged.
REQ-025 Latency from accept to packet on dout SHALL be exactly one cycle; sustained throughput one packet per cycle when resend=0.

Reset
REQ-026 reset SHALL dominate all inputs: state IDLE, dout 0, grant_id_o 0, drop_o 0, retry count 0, burst count 0, last_grant NUM_REQ-1 (requester 0 highest priority).
REQ-027 Reset during RETRY SHALL discard the held packet without asserting drop_o.

Configuration
REQ-028 Macro LEAF_ARB_BURST_EN defined: the last winner keeps priority while its req_valid_i stays high, up to BURST_LEN consecutive accepts, then round-robin resumes from it +1; burst count resets on grant change, bubble or reset.
REQ-029 Macro LEAF_ARB_BURST_EN undefined: strict one-packet-per-grant round-robin; no burst counter exists.

Structure
REQ-030 Package leaf_arb_pkg SHALL hold PKT_W, NUM_REQ, ID width constant and the FSM state enum.
REQ-031 Sub-module rr_picker SHALL implement the combinational round-robin search (inputs valid vector, last_grant; outputs one-hot and index, found flag).

Verification
REQ-032 All six requesters valid, resend=0, burst off -> dout grant order 0,1,2,3,4,5,0 on consecutive cycles, one ready per cycle.
REQ-033 Requester 3 sends 0x0_0000_0000_00AB, resend=1 for 2 cycles then 0 -> dout holds 1_0000_0000_00AB three cycles, no ready during hold.
REQ-034 resend held high 16 cycles on one packet (MAX_RETRY=15) -> dout 0 and drop_o=1 exactly once, next winner accepted afterwards.
REQ-035 Burst on, requester 2 valid 6 cycles, requester 4 valid -> grants 2,2,2,2,4,2.
REQ-036 reset asserted in RETRY and ap_start=0 mid-stream -> all outputs 0 next cycle, first grant after restart goes to requester 0.

Source files
------------

// File: rtl/leaf_arb_pkg.sv
// Shared constants and FSM state type for the BFT leaf arbiter.
package leaf_arb_pkg;
  localparam int LEAF_NUM_REQ = 6;
  localparam int LEAF_PKT_W   = 49;
  localparam int ID_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RETRY = 2'd2
  } arb_state_e;
endpackage

// File: rtl/page_leaf_arbiter_rr_picker.sv
// Combinational round-robin search: first valid requester above last_i, wrapping.
module rr_picker
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = LEAF_NUM_REQ,
  parameter int IW      = ID_W
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IW-1:0]      idx_o,
  output logic               found_o
);
  logic [IW-1:0] cand;

  // Scan last_i+1 .. last_i+NUM_REQ (mod NUM_REQ); the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_i) + k) % NUM_REQ);
      if (!found_o && valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
    onehot_o = found_o ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/page_leaf_arbiter.sv
// Round-robin arbiter feeding one BFT leaf port, with resend hold and drop after
// MAX_RETRY held cycles. Define LEAF_ARB_BURST_EN to let a winner keep the port
// for up to BURST_LEN back-to-back packets.
module page_leaf_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ   = LEAF_NUM_REQ,
  parameter int PKT_W     = LEAF_PKT_W,
  parameter int MAX_RETRY = 15,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic                     resend,
  input  logic [NUM_REQ*PKT_W-1:0] req_din_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [PKT_W-1:0]         dout_leaf_interface2bft,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     drop_o
);
  localparam int RC_W = $clog2(MAX_RETRY + 1);

  arb_state_e       state_q, state_d;
  logic [PKT_W-1:0] dout_q, dout_d;
  logic [ID_W-1:0]  grant_q, grant_d, last_q, last_d;
  logic             drop_q, drop_d;
  logic [RC_W-1:0]  retry_q, retry_d;

  logic [NUM_REQ-1:0] rr_onehot, pick_onehot;
  logic [ID_W-1:0]    rr_idx, win;
  logic               rr_found, found, active, hold, accept;
  logic [PKT_W-1:0]   pkt [NUM_REQ];
  logic [PKT_W-1:0]   sel_pkt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pkt
    assign pkt[g] = req_din_i[g*PKT_W +: PKT_W];
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(ID_W)) u_rr (
    .valid_i  (req_valid_i),
    .last_i   (last_q),
    .onehot_o (rr_onehot),
    .idx_o    (rr_idx),
    .found_o  (rr_found)
  );

`ifdef LEAF_ARB_BURST_EN
  localparam int BC_W = $clog2(BURST_LEN + 1);
  logic [BC_W-1:0] burst_q, burst_d;
  logic            sticky;

  // Current burst owner keeps the port while it stays valid and has budget left.
  assign sticky      = (burst_q != '0) && (burst_q < BC_W'(BURST_LEN)) && req_valid_i[last_q];
  assign win         = sticky ? last_q : rr_idx;
  assign found       = sticky | rr_found;
  assign pick_onehot = sticky ? (NUM_REQ'(1) << last_q) : rr_onehot;

  // Burst length tracks consecutive accepts of the same requester.
  always_comb begin
    burst_d = burst_q;
    if (accept)
      burst_d = (win == last_q && burst_q < BC_W'(BURST_LEN)) ? burst_q + 1'b1 : BC_W'(1);
    else if (!hold)
      burst_d = '0;
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (reset) burst_q <= '0;
    else       burst_q <= burst_d;
  end
`else
  logic unused_burst_len;
  assign unused_burst_len = ^BURST_LEN;
  assign win              = rr_idx;
  assign found            = rr_found;
  assign pick_onehot      = rr_onehot;
`endif

  // A valid packet on dout with resend high freezes everything; reset blocks accepts.
  assign active      = (state_q != ST_IDLE);
  assign hold        = active && dout_q[PKT_W-1] && resend;
  assign accept      = active && !hold && ap_start && found && !reset;
  assign req_ready_o = accept ? pick_onehot : '0;
  assign sel_pkt     = pkt[win];

  // Next-state, output and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    grant_d = grant_q;
    last_d  = last_q;
    drop_d  = 1'b0;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        dout_d  = '0;
        grant_d = '0;
        retry_d = '0;
        if (ap_start) state_d = ST_RUN;
      end
      default: begin
        if (hold) begin
          if (retry_q == RC_W'(MAX_RETRY)) begin
            dout_d  = '0;
            drop_d  = 1'b1;
            retry_d = '0;
            state_d = ST_RUN;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RETRY;
          end
        end else begin
          retry_d = '0;
          if (!ap_start) begin
            state_d = ST_IDLE;
            dout_d  = '0;
            grant_d = '0;
          end else begin
            state_d = ST_RUN;
            if (found) begin
              dout_d  = sel_pkt | (PKT_W'(1) << (PKT_W - 1));
              grant_d = win;
              last_d  = win;
            end else begin
              dout_d  = '0;
            end
          end
        end
      end
    endcase
  end

  // State and output registers; last_grant resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      drop_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      retry_q <= retry_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign grant_id_o              = grant_q;
  assign drop_o                  = drop_q;
endmodule

// File: tb/tb_page_leaf_arbiter.sv
// Self-checking bench for page_leaf_arbiter: table vectors, directed corner
// sequences and a randomized run against a behavioural model.
module tb_page_leaf_arbiter;
  localparam int NR = 6;
  localparam int PW = 49;
  localparam int MR = 15;
  localparam int BL = 4;

  typedef struct {
    logic          rst, start, rsnd;
    logic [NR-1:0] valid;
    logic [NR-1:0] e_ready;
    logic [PW-1:0] e_dout;
    logic [2:0]    e_grant;
    logic          e_drop;
  } vec_t;

  logic             clk, rst, ap_start, resend, drop;
  logic [NR*PW-1:0] din;
  logic [NR-1:0]    valid, ready, last_ready;
  logic [PW-1:0]    dout;
  logic [2:0]       grant;

  logic [PW-1:0] pk [NR];
  int errors = 0, checks = 0;

  // Behavioural model: "on" flag, outputs, last grant, held count, burst count.
  bit            m_on = 0, m_drop = 0;
  logic [PW-1:0] m_dout = '0;
  int            m_grant = 0, m_last = NR - 1, m_tries = 0, m_burst = 0;

  page_leaf_arbiter dut (
    .clk(clk), .reset(rst), .ap_start(ap_start), .resend(resend),
    .req_din_i(din), .req_valid_i(valid), .req_ready_o(ready),
    .dout_leaf_interface2bft(dout), .grant_id_o(grant), .drop_o(drop)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic rs, input logic [NR-1:0] v);
    vec_t t;
    t.rst = r; t.start = s; t.rsnd = rs; t.valid = v;
    t.e_ready = '0; t.e_dout = '0; t.e_grant = '0; t.e_drop = 1'b0;
    return t;
  endfunction

  function automatic int m_winner(input vec_t v);
    if (v.rst || !m_on || !v.start || (m_dout[PW-1] && v.rsnd)) return -1;
`ifdef LEAF_ARB_BURST_EN
    if (m_burst > 0 && m_burst < BL && v.valid[m_last]) return m_last;
`endif
    for (int k = 1; k <= NR; k++)
      if (v.valid[(m_last + k) % NR]) return (m_last + k) % NR;
    return -1;
  endfunction

  task automatic m_clock(input vec_t v, input int w);
    if (v.rst) begin
      m_on = 0; m_dout = '0; m_grant = 0; m_last = NR - 1; m_tries = 0; m_drop = 0; m_burst = 0;
    end else if (!m_on) begin
      m_on = v.start; m_dout = '0; m_grant = 0; m_drop = 0; m_tries = 0; m_burst = 0;
    end else if (m_dout[PW-1] && v.rsnd) begin
      if (m_tries == MR) begin m_dout = '0; m_drop = 1; m_tries = 0; end
      else begin m_tries++; m_drop = 0; end
    end else begin
      m_drop = 0; m_tries = 0;
      if (!v.start) begin
        m_on = 0; m_dout = '0; m_grant = 0; m_burst = 0;
      end else if (w >= 0) begin
        m_burst = (w == m_last && m_burst < BL) ? m_burst + 1 : 1;
        m_dout = pk[w]; m_dout[PW-1] = 1'b1; m_grant = w; m_last = w;
      end else begin
        m_dout = '0; m_burst = 0;
      end
    end
  endtask

  // One clock: drive, check combinational ready mid-cycle, then registered outputs.
  task automatic step(input vec_t v, input bit tchk);
    int w;
    logic [NR-1:0] er;
    rst = v.rst; ap_start = v.start; resend = v.rsnd; valid = v.valid;
    for (int i = 0; i < NR; i++) din[i*PW +: PW] = pk[i];
    #3;
    last_ready = ready;
    w = m_winner(v);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("ready", 64'(ready), 64'(er));
    if (tchk) chk("tbl_ready", 64'(ready), 64'(v.e_ready));
    m_clock(v, w);
    @(posedge clk); #1;
    chk("dout", 64'(dout), 64'(m_dout));
    chk("grant", 64'(grant), 64'(m_grant));
    chk("drop", 64'(drop), 64'(m_drop));
    if (tchk) begin
      chk("tbl_dout", 64'(dout), 64'(v.e_dout));
      chk("tbl_grant", 64'(grant), 64'(v.e_grant));
      chk("tbl_drop", 64'(drop), 64'(v.e_drop));
    end
  endtask

  initial begin
    vec_t tbl [9];
    vec_t v;
    int hits, drops, pct;
    int gl [6];
    int exp_gl [6];
    logic v4;

    for (int i = 0; i < NR; i++) pk[i] = PW'(4096 + i);
    rst = 1; ap_start = 0; resend = 0; valid = '0; din = '0; last_ready = '0;

    // Reset, start, then all six valid: grants 0..5,0 one per cycle.
    tbl[0] = mk(1, 0, 0, '0);
    tbl[1] = mk(0, 1, 0, 6'h3F);
    for (int k = 0; k < 7; k++) begin
      v = mk(0, 1, 0, 6'h3F);
      v.e_ready = NR'(1) << (k % NR);
      v.e_dout  = {1'b1, 48'(4096 + k % NR)};
      v.e_grant = 3'(k % NR);
      tbl[2 + k] = v;
    end
    for (int r = 0; r < 9; r++) step(tbl[r], 1);

    // Resend holds requester 3's packet for two extra cycles.
    step(mk(1, 0, 0, '0), 0);
    step(mk(0, 1, 0, '0), 0);
    pk[3] = PW'(48'hAB);
    hits = 0;
    step(mk(0, 1, 0, 6'h08), 0);
    chk("a_accept_ready", 64'(last_ready), 64'h08);
    if (dout == {1'b1, 48'hAB}) hits++;
    for (int i = 0; i < 2; i++) begin
      step(mk(0, 1, 1, 6'h08), 0);
      chk("a_hold_ready", 64'(last_ready), 64'h0);
      if (dout == {1'b1, 48'hAB}) hits++;
    end
    step(mk(0, 1, 0, '0), 0);
    if (dout == {1'b1, 48'hAB}) hits++;
    chk("a_hold_cycles", 64'(hits), 64'd3);
    chk("a_bubble", 64'(dout), 64'h0);

    // Sixteen resend cycles drop the packet once; requester 2 goes next.
    step(mk(1, 0, 0, '0), 0);
    step(mk(0, 1, 0, '0), 0);
    step(mk(0, 1, 0, 6'h02), 0);
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      step(mk(0, 1, 1, 6'h04), 0);
      if (drop) drops++;
      if (i < 15) chk("b_held", 64'(dout), 64'({1'b1, pk[1][PW-2:0]}));
    end
    chk("b_drop_dout", 64'(dout), 64'h0);
    chk("b_drop_pulse", 64'(drop), 64'h1);
    step(mk(0, 1, 0, 6'h04), 0);
    if (drop) drops++;
    chk("b_next_grant", 64'(grant), 64'd2);
    chk("b_drop_once", 64'(drops), 64'd1);

    // Reset while retrying, then ap_start dropped mid-stream.
    step(mk(0, 1, 0, 6'h3F), 0);
    step(mk(0, 1, 0, 6'h3F), 0);
    step(mk(0, 1, 1, 6'h3F), 0);
    step(mk(0, 1, 1, 6'h3F), 0);
    step(mk(1, 1, 1, 6'h3F), 0);
    chk("c_rst_dout", 64'(dout), 64'h0);
    chk("c_rst_grant", 64'(grant), 64'h0);
    chk("c_rst_drop", 64'(drop), 64'h0);
    step(mk(0, 0, 1, 6'h3F), 0);
    chk("c_idle_ready", 64'(last_ready), 64'h0);
    step(mk(0, 1, 0, 6'h3F), 0);
    step(mk(0, 1, 0, 6'h3F), 0);
    chk("c_first_grant", 64'(grant), 64'd0);
    step(mk(0, 1, 0, 6'h3F), 0);
    step(mk(0, 0, 0, 6'h3F), 0);
    chk("c_stop_ready", 64'(last_ready), 64'h0);
    chk("c_stop_dout", 64'(dout), 64'h0);
    chk("c_stop_grant", 64'(grant), 64'h0);
    step(mk(0, 0, 0, 6'h3F), 0);

`ifdef LEAF_ARB_BURST_EN
    // Requester 2 bursts four packets, yields once to 4, then resumes.
    exp_gl = '{2, 2, 2, 2, 4, 2};
    step(mk(1, 0, 0, '0), 0);
    step(mk(0, 1, 0, '0), 0);
    v4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(mk(0, 1, 0, {1'b0, v4, 1'b0, 1'b1, 2'b00}), 0);
      gl[i] = int'(grant);
      if (grant == 3'd4) v4 = 1'b0;
    end
    for (int i = 0; i < 6; i++) chk("d_burst_grant", 64'(gl[i]), 64'(exp_gl[i]));
`else
    exp_gl = '{0, 0, 0, 0, 0, 0};
    gl = exp_gl;
    v4 = 1'b0;
`endif

    // Randomized traffic, alternating light and heavy resend pressure.
    pct = 97;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) pct = (pct == 30) ? 97 : 30;
      for (int i = 0; i < NR; i++) pk[i] = PW'({$urandom, $urandom});
      step(mk(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
              ($urandom_range(0, 99) < pct), NR'($urandom)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
